// File: rtl/weight_fifo_pkg.sv
// Shared constants and types for the tile-granular weight FIFO.
package weight_fifo_pkg;

    localparam int unsigned MUL_SIZE          = 4;  // rows per tile = lanes per row
    localparam int unsigned DATA_W            = 8;  // bits per weight lane
    localparam int unsigned WEIGHT_FIFO_TILES = 2;  // default tile capacity
    localparam int unsigned ROW_W             = MUL_SIZE * DATA_W;
    localparam int unsigned ROW_IDX_W         = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;

    typedef logic [DATA_W-1:0] weight_t;
    typedef weight_t           weight_row_t [MUL_SIZE];
    typedef logic [ROW_W-1:0]  row_bits_t;

    // Read side: idle at a tile boundary, streaming once a tile's first row has popped.
    typedef enum logic [0:0] {
        RIdle,
        RStream
    } rd_state_e;

endpackage

// File: rtl/weight_fifo_if.sv
// Write-side row handshake between the host/DRAM feeder (master) and the FIFO (slave).
interface weight_fifo_if;
    import weight_fifo_pkg::*;

    logic      wr_valid;
    logic      wr_ready;
    row_bits_t wr_row;

    modport master (output wr_valid, output wr_row, input wr_ready);
    modport slave  (input wr_valid, input wr_row, output wr_ready);

endinterface

// File: rtl/weight_fifo_ram.sv
// Simple dual-port row store: one write port, one registered read port with sync clear.
module weight_fifo_ram #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 32,
    parameter int unsigned AddrW = 3
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] rdata_d, rdata_q;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read register next state: clear wins, otherwise load on read enable.
    always_comb begin
        rdata_d = rdata_q;
        if (clr_i) begin
            rdata_d = '0;
        end else if (re_i) begin
            rdata_d = mem[raddr_i];
        end
    end

    // Read output register.
    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_fifo.sv
// Tile-granular weight FIFO: rows are only readable once a whole tile is stored.
// Optional feature macro: WEIGHT_FIFO_ERR_EN adds a sticky err_underrun_o flag.
module weight_fifo
    import weight_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_TILES = WEIGHT_FIFO_TILES
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    weight_fifo_if.slave                     wr_if,
    input  logic                             load_weights_i,
    output logic                             weight_fifo_valid_output_o,
    output row_bits_t                        weight_row_o,
    output logic                             weight_row_valid_o,
    output logic                             weight_last_row_o,
    output logic [$clog2(DEPTH_TILES+1)-1:0] tile_count_o
`ifdef WEIGHT_FIFO_ERR_EN
    ,
    output logic                             err_underrun_o
`endif
);

    localparam int unsigned DEPTH_ROWS = DEPTH_TILES * MUL_SIZE;
    localparam int unsigned PTR_W      = (DEPTH_ROWS > 1) ? $clog2(DEPTH_ROWS) : 1;
    localparam int unsigned OCC_W      = $clog2(DEPTH_ROWS + 1);
    localparam int unsigned TCNT_W     = $clog2(DEPTH_TILES + 1);

    logic [PTR_W-1:0]     wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [ROW_IDX_W-1:0] wr_row_d, wr_row_q, rd_row_d, rd_row_q;
    logic [OCC_W-1:0]     occ_d, occ_q;
    logic [TCNT_W-1:0]    tile_cnt_d, tile_cnt_q;
    logic                 row_valid_d, row_valid_q;
    logic                 last_row_d, last_row_q;
    rd_state_e            rd_state_d, rd_state_q;
    logic                 err_d, err_q;

    logic clr, push, pop, wr_last, rd_last;

    assign clr     = rst_i | flush_i;
    assign wr_if.wr_ready = (occ_q < OCC_W'(DEPTH_ROWS));
    assign push    = wr_if.wr_valid & wr_if.wr_ready;
    // Only complete tiles are poppable, so the read pointer never reaches a partial tile.
    assign pop     = load_weights_i & (tile_cnt_q != '0);
    assign wr_last = (wr_row_q == ROW_IDX_W'(MUL_SIZE - 1));
    assign rd_last = (rd_row_q == ROW_IDX_W'(MUL_SIZE - 1));

    // Next-state for pointers, row counters, occupancy, tile count and read FSM.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_row_d    = wr_row_q;
        rd_row_d    = rd_row_q;
        occ_d       = occ_q;
        tile_cnt_d  = tile_cnt_q;
        rd_state_d  = rd_state_q;
        err_d       = err_q;
        row_valid_d = 1'b0;
        last_row_d  = 1'b0;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            wr_row_d   = '0;
            rd_row_d   = '0;
            occ_d      = '0;
            tile_cnt_d = '0;
            rd_state_d = RIdle;
            err_d      = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH_ROWS - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                wr_row_d = wr_last ? '0 : wr_row_q + ROW_IDX_W'(1);
            end
            if (pop) begin
                rd_ptr_d    = (rd_ptr_q == PTR_W'(DEPTH_ROWS - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                rd_row_d    = rd_last ? '0 : rd_row_q + ROW_IDX_W'(1);
                row_valid_d = 1'b1;
                last_row_d  = rd_last;
                rd_state_d  = rd_last ? RIdle : RStream;
            end
            if (load_weights_i && tile_cnt_q == '0) begin
                err_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
            case ({push & wr_last, pop & rd_last})
                2'b10:   tile_cnt_d = tile_cnt_q + TCNT_W'(1);
                2'b01:   tile_cnt_d = tile_cnt_q - TCNT_W'(1);
                default: tile_cnt_d = tile_cnt_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        wr_row_q    <= wr_row_d;
        rd_row_q    <= rd_row_d;
        occ_q       <= occ_d;
        tile_cnt_q  <= tile_cnt_d;
        rd_state_q  <= rd_state_d;
        row_valid_q <= row_valid_d;
        last_row_q  <= last_row_d;
        err_q       <= err_d;
    end

    weight_fifo_ram #(
        .Depth (DEPTH_ROWS),
        .Width (ROW_W),
        .AddrW (PTR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .clr_i   (clr),
        .we_i    (push & ~clr),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_if.wr_row),
        .re_i    (pop & ~clr),
        .raddr_i (rd_ptr_q),
        .rdata_o (weight_row_o)
    );

    assign weight_fifo_valid_output_o = (tile_cnt_q != '0);
    assign weight_row_valid_o         = row_valid_q;
    assign weight_last_row_o          = last_row_q;
    assign tile_count_o               = tile_cnt_q;

`ifdef WEIGHT_FIFO_ERR_EN
    assign err_underrun_o = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_weight_fifo.sv
// Directed self-checking bench for weight_fifo (MUL_SIZE=4, DEPTH_TILES=2).
module tb_weight_fifo;
    import weight_fifo_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      flush = 1'b0;
    logic      load = 1'b0;
    logic      valid_out;
    row_bits_t row_out;
    logic      row_valid;
    logic      last_row;
    logic [1:0] tile_cnt;
`ifdef WEIGHT_FIFO_ERR_EN
    logic      err_underrun;
`endif

    int nvec = 0;
    int nerr = 0;

    weight_fifo_if wr_if ();

    weight_fifo #(
        .DEPTH_TILES (2)
    ) dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .flush_i                    (flush),
        .wr_if                      (wr_if),
        .load_weights_i             (load),
        .weight_fifo_valid_output_o (valid_out),
        .weight_row_o               (row_out),
        .weight_row_valid_o         (row_valid),
        .weight_last_row_o          (last_row),
        .tile_count_o               (tile_cnt)
`ifdef WEIGHT_FIFO_ERR_EN
        ,
        .err_underrun_o             (err_underrun)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic row_bits_t row_of(input logic [7:0] b);
        return {MUL_SIZE{b}};
    endfunction

    task automatic push_row(input logic [7:0] b);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_row   = row_of(b);
        tick();
        wr_if.wr_valid = 1'b0;
    endtask

    // Pop one row and check the registered output one cycle later.
    task automatic pop_chk(input string tag, input logic [7:0] b, input logic last);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk({tag, "_valid"}, 64'(row_valid), 64'd1);
        chk({tag, "_row"}, 64'(row_out), 64'(row_of(b)));
        chk({tag, "_last"}, 64'(last_row), 64'(last));
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_row   = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 64'(wr_if.wr_ready), 64'd1);
        chk("rst_vout", 64'(valid_out), 64'd0);
        chk("rst_tiles", 64'(tile_cnt), 64'd0);
        chk("rst_rvalid", 64'(row_valid), 64'd0);
        chk("rst_row", 64'(row_out), 64'd0);
`ifdef WEIGHT_FIFO_ERR_EN
        chk("rst_err", 64'(err_underrun), 64'd0);
`endif

        // Partial tile is not readable
        push_row(8'h11);
        push_row(8'h22);
        push_row(8'h33);
        chk("part_vout", 64'(valid_out), 64'd0);
        chk("part_tiles", 64'(tile_cnt), 64'd0);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("part_pop_ign", 64'(row_valid), 64'd0);
`ifdef WEIGHT_FIFO_ERR_EN
        chk("err_set", 64'(err_underrun), 64'd1);
`endif
        push_row(8'h44);
        chk("tile_vout", 64'(valid_out), 64'd1);
        chk("tile_cnt1", 64'(tile_cnt), 64'd1);
        pop_chk("p11", 8'h11, 1'b0);
        chk("mid_vout", 64'(valid_out), 64'd1);
        pop_chk("p22", 8'h22, 1'b0);
        pop_chk("p33", 8'h33, 1'b0);
        pop_chk("p44", 8'h44, 1'b1);
        chk("drain_vout", 64'(valid_out), 64'd0);
        chk("drain_tiles", 64'(tile_cnt), 64'd0);
        tick();
        chk("drain_rvalid", 64'(row_valid), 64'd0);

        // Fill to capacity; offer one extra row that must be refused
        for (int i = 0; i < 8; i++) push_row(8'h50 + 8'(i));
        chk("full_ready", 64'(wr_if.wr_ready), 64'd0);
        chk("full_tiles", 64'(tile_cnt), 64'd2);
        push_row(8'hEE);
        chk("full_ready2", 64'(wr_if.wr_ready), 64'd0);
        pop_chk("f50", 8'h50, 1'b0);
        chk("pop1_ready", 64'(wr_if.wr_ready), 64'd1);
        for (int i = 1; i < 8; i++) pop_chk("fdrain", 8'h50 + 8'(i), (i % 4) == 3);
        chk("fill_empty", 64'(tile_cnt), 64'd0);

        // Concurrent push/pop after one tile preload, crossing pointer wrap
        for (int i = 0; i < 4; i++) push_row(8'h80 + 8'(i));
        for (int c = 0; c < 40; c++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_row   = row_of(8'h84 + 8'(c));
            load           = 1'b1;
            tick();
            chk("st_row", 64'(row_out), 64'(row_of(8'h80 + 8'(c))));
            chk("st_valid", 64'(row_valid), 64'd1);
            chk("st_last", 64'(last_row), 64'((c % 4) == 3));
            chk("st_tiles", 64'(tile_cnt), 64'd1);
            chk("st_ready", 64'(wr_if.wr_ready), 64'd1);
        end
        wr_if.wr_valid = 1'b0;
        load           = 1'b0;
        tick();
        chk("st_end_tiles", 64'(tile_cnt), 64'd1);

        // Pause mid-tile: rows A8..AB remain
        pop_chk("pa8", 8'hA8, 1'b0);
        pop_chk("pa9", 8'hA9, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("pause_rvalid", 64'(row_valid), 64'd0);
        chk("pause_vout", 64'(valid_out), 64'd1);
        pop_chk("paa", 8'hAA, 1'b0);
        pop_chk("pab", 8'hAB, 1'b1);
        chk("pause_done", 64'(tile_cnt), 64'd0);

        // Flush mid-tile with a same-cycle push and pop
        for (int i = 0; i < 5; i++) push_row(8'hC0 + 8'(i));
        pop_chk("pc0", 8'hC0, 1'b0);
        flush          = 1'b1;
        load           = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_row   = row_of(8'hDD);
        tick();
        flush          = 1'b0;
        load           = 1'b0;
        wr_if.wr_valid = 1'b0;
        chk("fl_tiles", 64'(tile_cnt), 64'd0);
        chk("fl_vout", 64'(valid_out), 64'd0);
        chk("fl_ready", 64'(wr_if.wr_ready), 64'd1);
        chk("fl_rvalid", 64'(row_valid), 64'd0);
        chk("fl_row", 64'(row_out), 64'd0);
`ifdef WEIGHT_FIFO_ERR_EN
        chk("fl_err", 64'(err_underrun), 64'd0);
`endif
        for (int i = 0; i < 4; i++) push_row(8'hE0 + 8'(i));
        chk("post_fl_tiles", 64'(tile_cnt), 64'd1);
        for (int i = 0; i < 4; i++) pop_chk("pe", 8'hE0 + 8'(i), i == 3);

`ifdef WEIGHT_FIFO_ERR_EN
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("err_empty", 64'(err_underrun), 64'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("err_hold", 64'(err_underrun), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("err_clr", 64'(err_underrun), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
